hdmi_pixel_stage: RTL
=====================

# hdmi_pixel_stage

Pixel-output stage placed directly downstream of the 1024x768 video timing generator and upstream of the HDMI/TMDS encoder. It consumes the generator's hs/vs/de and active_x/active_y. It pulls RGB565 pixels from a first-word-fall-through read FIFO filled by the DDR3 frame-buffer reader, expands them to RGB888, and delays the syncs so they stay aligned with pixel data. It also handles frame alignment, FIFO underflow recovery, and a colour-bar test pattern.

## Interface
Parameters:
- LATENCY, 2: pipeline depth from timing inputs to outputs; fixed at 2.
- VS_POL, 1'b0: active level of the vs input.
- FILL_RGB, 24'h000000: colour output while unaligned or after underflow.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- hs  in  1  horizontal sync from timing generator
- vs  in  1  vertical sync from timing generator
- de  in  1  active video from timing generator
- active_x  in  10  pixel column
- active_y  in  10  pixel row (used only for the pattern's last-row check)
- pattern_en  in  1  1 = colour bars instead of FIFO data
- fifo_rd_data  in  16  RGB565 {R5,G6,B5}, FWFT (valid while !fifo_empty)
- fifo_empty  in  1  FIFO empty
- fifo_rd_en  out  1  pop the FIFO head
- frame_start  out  1  one-cycle pulse on the vs assertion edge
- fifo_flush  out  1  one-cycle pulse coincident with frame_start when the previous frame underflowed
- out_hs  out  1  hs delayed by LATENCY
- out_vs  out  1  vs delayed by LATENCY
- out_de  out  1  de delayed by LATENCY
- out_r  out  8  red component
- out_g  out  8  green component
- out_b  out  8  blue component
- underflow_cnt  out  16  saturating count of frames that underflowed
- aligned  out  1  high while in the ACTIVE state

## Operation
- Frame-start detect: register vs; the frame-start edge is vs_d != VS_POL && vs == VS_POL. frame_start is registered (asserted one cycle after the edge).
- State machine: WAIT_FRAME, ACTIVE, UNDERFLOW.
  - Reset → WAIT_FRAME.
  - WAIT_FRAME → ACTIVE on frame_start.
  - ACTIVE → UNDERFLOW when de && !pattern_en && fifo_empty.
  - UNDERFLOW → ACTIVE on frame_start, with fifo_flush pulsed on the same cycle.
  - If frame_start and an underflow condition occur in the same cycle, frame_start wins: the state goes to ACTIVE.
- fifo_rd_en = de && !fifo_empty && !pattern_en && state==ACTIVE. It is combinational, and the FIFO is never popped when empty.
- Pixel source, chosen in stage 1:
  - pattern_en → bars;
  - state==ACTIVE and a pop occurs → fifo_rd_data;
  - otherwise → FILL_RGB.
- Colour bars: index = active_x[9:7], giving 8 bars of 128 px. Colours in order: white, yellow, cyan, green, magenta, red, blue, black. Row active_y==767 is forced to white.
- RGB565→888 expansion uses MSB replication: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
- underflow_cnt increments once per ACTIVE→UNDERFLOW transition and saturates at 16'hFFFF.
- pattern_en may change at any time. The change takes effect on the next pixel and never causes an underflow.

## Timing
- Stage 1 registers: hs, vs, de, source select, raw pixel (FIFO/fill/bar) and the colour-bar index.
- Stage 2 registers: the expanded RGB888 and the delayed syncs. Total latency is 2 cycles for all outputs, in lock-step.
- out_r/g/b are forced to 0 when out_de is low.
- Reset values:
  - out_hs, out_vs: !VS_POL-style idle levels, i.e. 1'b1 for the default polarity.
  - out_de = 0; out_r/g/b = 0.
  - frame_start = 0; fifo_flush = 0; fifo_rd_en = 0.
  - underflow_cnt = 0; aligned = 0; state = WAIT_FRAME.
- Reset asserted mid-frame clears everything asynchronously. After release, the block outputs FILL_RGB until the next frame_start.
- Underflow pixel timing: the pixel at which fifo_empty is first seen and all later de pixels of that frame output FILL_RGB. fifo_rd_en stays low for the rest of the frame even if the FIFO refills.

## Structure
- Shared video package holds:
  - localparam H_ACTIVE=1024, V_ACTIVE=768;
  - the colour-bar RGB888 constants;
  - the state encoding (2-bit enum: WAIT_FRAME=0, ACTIVE=1, UNDERFLOW=2).
- One sub-module is natural: rgb565_to_888, a combinational expansion instantiated in stage 2.

## Test plan
- Reset release mid-frame, FIFO holding 16'hF800 → FILL output and fifo_rd_en=0 until vs falls. Next frame's first pixel is out_r=FF, out_g=00, out_b=00, arriving exactly 2 cycles after de.
- Full frame with FIFO always non-empty → exactly 1024×768 pops, underflow_cnt=0, out_de/out_hs/out_vs equal to the inputs delayed by 2 cycles.
- FIFO empty at pixel (500,300) → FILL from that pixel on, underflow_cnt=1, then fifo_flush=1 together with the next frame_start, and the next frame proceeds normally.
- pattern_en=1 → active_x=0..127 gives FFFFFF, 128..255 gives FFFF00, 896..1023 gives 000000, and row 767 is all FFFFFF. fifo_rd_en stays 0 and there is no underflow with an empty FIFO.
- Frame-start edge on the same cycle as an empty-FIFO de → state goes to ACTIVE and underflow_cnt is unchanged.
- Force 65536 underflowing frames (counter preloaded via a short run or test hook) → underflow_cnt saturates at FFFF.

Source files
------------

// File: rtl/hdmi_pixel_stage_pkg.sv
// Shared video definitions for the HDMI pixel-output stage.
// Holds the 1024x768 active geometry, the colour-bar palette, the alignment
// state encoding and the stage-1 pixel source encoding.
package hdmi_pixel_stage_pkg;

  localparam int H_ACTIVE = 1024;
  localparam int V_ACTIVE = 768;

  // Colour-bar palette, left to right across the active line.
  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACTIVE     = 2'd1,
    UNDERFLOW  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SRC_FILL = 2'd0,
    SRC_FIFO = 2'd1,
    SRC_BAR  = 2'd2
  } src_t;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hdmi_pixel_stage_rgb565_to_888.sv
// Combinational RGB565 -> RGB888 expansion by MSB replication, so that full
// scale maps to full scale (5'h1F -> 8'hFF) and zero stays zero.
// Ports:
//   rgb565 : {R5,G6,B5} input pixel
//   rgb888 : {R8,G8,B8} expanded pixel
module hdmi_pixel_stage_rgb565_to_888 (
  input  logic [15:0] rgb565,
  output logic [23:0] rgb888
);

  logic [4:0] r5;
  logic [5:0] g6;
  logic [4:0] b5;

  assign r5 = rgb565[15:11];
  assign g6 = rgb565[10:5];
  assign b5 = rgb565[4:0];

  assign rgb888 = {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};

endmodule

// File: rtl/hdmi_pixel_stage.sv
// Pixel-output stage between the video timing generator and the TMDS encoder.
// Pulls RGB565 pixels from a FWFT FIFO, expands them to RGB888 and delays the
// syncs by two clocks so sync and pixel data leave in lock-step. Aligns to the
// frame-start edge of vs, recovers from FIFO underflow at the next frame, and
// can substitute an 8-bar colour test pattern.
// Ports:
//   clk, rst                    : pixel clock, async active-high reset
//   hs, vs, de                  : timing generator syncs / active video
//   active_x, active_y          : current pixel column / row
//   pattern_en                  : 1 = colour bars instead of FIFO data
//   fifo_rd_data, fifo_empty    : FWFT FIFO head and empty flag
//   fifo_rd_en                  : pop the FIFO head (combinational)
//   frame_start                 : one-cycle pulse after the vs assertion edge
//   fifo_flush                  : pulse with frame_start after an underflowed frame
//   out_hs, out_vs, out_de      : syncs delayed by two clocks
//   out_r, out_g, out_b         : RGB888 pixel, zero outside active video
//   underflow_cnt               : saturating count of underflowed frames
//   aligned                     : high while locked to the frame (ACTIVE)
module hdmi_pixel_stage
  import hdmi_pixel_stage_pkg::*;
#(
  parameter int          LATENCY  = 2,
  parameter logic        VS_POL   = 1'b0,
  parameter logic [23:0] FILL_RGB = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs,
  input  logic        vs,
  input  logic        de,
  input  logic [9:0]  active_x,
  input  logic [9:0]  active_y,
  input  logic        pattern_en,
  input  logic [15:0] fifo_rd_data,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic        frame_start,
  output logic        fifo_flush,
  output logic        out_hs,
  output logic        out_vs,
  output logic        out_de,
  output logic [7:0]  out_r,
  output logic [7:0]  out_g,
  output logic [7:0]  out_b,
  output logic [15:0] underflow_cnt,
  output logic        aligned
);

  // The pipeline below is built for exactly two stages.
  if (LATENCY != 2) begin : g_latency_check
    $error("hdmi_pixel_stage supports LATENCY == 2 only");
  end

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state;
  logic [15:0] uf_cnt_q;
  logic        vs_edge;
  logic        pop;
  logic        underflow_hit;

  src_t        src_p0;
  logic [2:0]  bar_idx_p0;

  logic        hs_p1;
  logic        vs_p1;
  logic        de_p1;
  src_t        src_p1;
  logic [15:0] pix565_p1;
  logic [2:0]  bar_idx_p1;
  logic [23:0] fifo888_p1;
  logic [23:0] rgb_p1;

  // Only the bar index (top three bits) of the column is needed.
  logic unused_x;
  assign unused_x = &{1'b0, active_x[6:0]};

  // vs_p1 doubles as the delayed vs for edge detection.
  assign vs_edge = (vs_p1 != VS_POL) && (vs == VS_POL);

  assign pop        = de && !fifo_empty && !pattern_en && (state == ACTIVE);
  assign fifo_rd_en = pop;

  // A pixel landing on the frame boundary (edge cycle or frame_start cycle)
  // belongs to the new frame, so it cannot push the FSM into UNDERFLOW.
  assign underflow_hit = (state == ACTIVE) && de && !pattern_en && fifo_empty &&
                         !frame_start && !vs_edge;

  assign underflow_cnt = uf_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_FRAME;
      aligned     <= 1'b0;
      frame_start <= 1'b0;
      fifo_flush  <= 1'b0;
      uf_cnt_q    <= 16'h0000;
    end else begin
      frame_start <= vs_edge;
      fifo_flush  <= vs_edge && (state == UNDERFLOW);
      case (state)
        WAIT_FRAME: begin
          if (frame_start) begin
            state   <= ACTIVE;
            aligned <= 1'b1;
          end
        end
        ACTIVE: begin
          if (underflow_hit) begin
            state    <= UNDERFLOW;
            aligned  <= 1'b0;
            uf_cnt_q <= sat_inc16(uf_cnt_q);
          end
        end
        UNDERFLOW: begin
          if (frame_start) begin
            state   <= ACTIVE;
            aligned <= 1'b1;
          end
        end
        default: begin
          state   <= WAIT_FRAME;
          aligned <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    src_p0 = SRC_FILL;
    if (pattern_en) begin
      src_p0 = SRC_BAR;
    end else if (pop) begin
      src_p0 = SRC_FIFO;
    end
  end

  // Bottom row is forced to white (bar 0) to frame the pattern.
  assign bar_idx_p0 = (active_y == 10'(V_ACTIVE - 1)) ? 3'd0 : active_x[9:7];

  // ---- stage 1: timing, source select, raw pixel, bar index ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_p1  <= ~VS_POL;
      vs_p1  <= ~VS_POL;
      de_p1  <= 1'b0;
      src_p1 <= SRC_FILL;
    end else begin
      hs_p1  <= hs;
      vs_p1  <= vs;
      de_p1  <= de;
      src_p1 <= src_p0;
    end
  end

  always_ff @(posedge clk) begin
    pix565_p1  <= fifo_rd_data;
    bar_idx_p1 <= bar_idx_p0;
  end

  hdmi_pixel_stage_rgb565_to_888 u_expand (
    .rgb565 (pix565_p1),
    .rgb888 (fifo888_p1)
  );

  always_comb begin
    rgb_p1 = FILL_RGB;
    case (src_p1)
      SRC_FIFO: rgb_p1 = fifo888_p1;
      SRC_BAR:  rgb_p1 = bar_color(bar_idx_p1);
      default:  rgb_p1 = FILL_RGB;
    endcase
    if (!de_p1) begin
      rgb_p1 = 24'h000000;
    end
  end

  // ---- stage 2: expanded RGB888 and delayed syncs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_hs <= ~VS_POL;
      out_vs <= ~VS_POL;
      out_de <= 1'b0;
      out_r  <= 8'h00;
      out_g  <= 8'h00;
      out_b  <= 8'h00;
    end else begin
      out_hs <= hs_p1;
      out_vs <= vs_p1;
      out_de <= de_p1;
      out_r  <= rgb_p1[23:16];
      out_g  <= rgb_p1[15:8];
      out_b  <= rgb_p1[7:0];
    end
  end

endmodule
